icache_direct_mapped: RTL and testbench

Direct-mapped, read-only instruction cache between the instruction fetch unit and instruction memory. Takes the fetch PC and returns the 32-bit instruction on a hit with zero added latency. On a miss it asserts busywait, which stalls the PC, and refills one 128-bit block from instruction memory through a busywait handshake.

---
 rtl/icache_direct_mapped.sv | 117 +++++++++++
 tb/tb_icache_direct_mapped.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache. Hits return the instruction in
// the same cycle; misses stall fetch and refill one 128-bit block from memory.
module icache_direct_mapped #(
  parameter int unsigned INDEX_W   = 3,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [31:0]   address,
  output logic [31:0]   instruction,
  output logic          busywait,
  output logic          mem_read,
  output logic [27:0]   mem_address,
  input  logic [127:0]  mem_readdata,
  input  logic          mem_busywait
);

  localparam int unsigned NBLK  = 1 << INDEX_W;
  localparam int unsigned TAG_W = 28 - INDEX_W;
  localparam logic [31:0] IDLE_ADDR = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } state_e;

  state_e             state_q;
  logic [NBLK-1:0]    valid_q;
  logic [TAG_W-1:0]   tag_q  [NBLK];
  logic [127:0]       data_q [NBLK];
  logic [127:0]       refill_q;
  logic [27:0]        miss_addr_q;
  logic               mem_read_q;

  logic [INDEX_W-1:0] idx_c;
  logic [TAG_W-1:0]   tag_c;
  logic [1:0]         off_c;
  logic [INDEX_W-1:0] miss_idx_c;
  logic               idle_addr_c;
  logic               hit_c;
  logic               miss_c;
  logic [127:0]       blk_c;

  // Lookup: split the fetch PC and compare against the indexed block.
  always_comb begin
    idx_c       = address[4 +: INDEX_W];
    tag_c       = address[31 -: TAG_W];
    off_c       = address[3:2];
    miss_idx_c  = miss_addr_q[INDEX_W-1:0];
    idle_addr_c = (address == IDLE_ADDR);
    blk_c       = data_q[idx_c];
    hit_c       = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
    miss_c      = !idle_addr_c && !hit_c;
  end

  // Stall and instruction select; reset forces the quiet state.
  always_comb begin
    busywait    = 1'b0;
    instruction = NOP_INSTR;
    if (reset) begin
      busywait = (state_q != S_IDLE) || miss_c;
      if ((state_q == S_IDLE) && hit_c && !idle_addr_c) begin
        instruction = blk_c[{off_c, 5'b0} +: 32];
      end
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_address = miss_addr_q;

  // Control: refill sequencing and valid bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
      mem_read_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (miss_c) begin
            miss_addr_q <= address[31:4];
            mem_read_q  <= 1'b1;
            state_q     <= S_MEM_READ;
          end
        end
        S_MEM_READ: begin
          if (!mem_busywait) begin
            mem_read_q <= 1'b0;
            state_q    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          valid_q[miss_idx_c] <= 1'b1;
          state_q             <= S_IDLE;
        end
        default: begin
          mem_read_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath storage is not reset; validity is tracked by valid_q alone.
  always_ff @(posedge clock) begin
    if ((state_q == S_MEM_READ) && !mem_busywait) begin
      refill_q <= mem_readdata;
    end
    if (state_q == S_UPDATE) begin
      data_q[miss_idx_c] <= refill_q;
      tag_q[miss_idx_c]  <= miss_addr_q[27 -: TAG_W];
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped: directed scenarios plus a
// randomized fetch stream compared against an array model of cache contents.
module tb_icache_direct_mapped;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] IDLE = 32'hFFFF_FFFC;

  logic          clock;
  logic          reset;
  logic [31:0]   address;
  logic [31:0]   instruction;
  logic          busywait;
  logic          mem_read;
  logic [27:0]   mem_address;
  logic [127:0]  mem_readdata;
  logic          mem_busywait;

  icache_direct_mapped dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Count rising edges of mem_read as seen at each clock edge.
  int   rd_pulses = 0;
  logic mr_prev   = 1'b0;
  always @(posedge clock) begin
    mr_prev <= mem_read;
    if (mem_read && !mr_prev) rd_pulses <= rd_pulses + 1;
  end

  // Reference model: instruction memory contents and cached blocks.
  logic [127:0] mem [logic [27:0]];
  logic         m_valid [8];
  logic [24:0]  m_tag   [8];
  logic [127:0] m_data  [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] get_blk(input logic [27:0] b);
    if (!mem.exists(b)) mem[b] = {$urandom, $urandom, $urandom, $urandom};
    return mem[b];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endtask

  // One fetch, entered at posedge+1, leaves at the posedge+1 after the
  // instruction is delivered. lat = cycles memory holds busywait high.
  task automatic fetch(input logic [31:0] a, input int lat);
    logic [2:0]   idx;
    logic [24:0]  tg;
    logic [127:0] blk;
    logic [127:0] line;
    int           off;
    idx          = a[6:4];
    tg           = a[31:7];
    off          = int'(a[3:2]);
    address      = a;
    mem_busywait = 1'b0;
    #3;
    if (a == IDLE) begin
      chk("idle_busy", 32'(busywait), 32'd0);
      chk("idle_instr", instruction, NOP);
      chk("idle_mem_read", 32'(mem_read), 32'd0);
    end else if (m_valid[idx] && m_tag[idx] == tg) begin
      line = m_data[idx];
      chk("hit_busy", 32'(busywait), 32'd0);
      chk("hit_instr", instruction, line[off*32 +: 32]);
      chk("hit_mem_read", 32'(mem_read), 32'd0);
    end else begin
      blk = get_blk(a[31:4]);
      mem_readdata = ~blk;
      chk("miss_busy", 32'(busywait), 32'd1);
      chk("miss_instr", instruction, NOP);
      for (int k = 1; k <= lat + 3; k++) begin
        @(posedge clock); #1;
        mem_busywait = (k <= lat);
        mem_readdata = (k <= lat) ? ~blk : blk;
        #3;
        chk("refill_mem_read", 32'(mem_read), 32'(k <= lat + 1));
        if (k <= lat + 1) chk("refill_mem_addr", 32'(mem_address), 32'(a[31:4]));
        chk("refill_busy", 32'(busywait), 32'(k < lat + 3));
        if (k < lat + 3) chk("refill_instr_nop", instruction, NOP);
      end
      mem_busywait = 1'b0;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = blk;
      chk("refill_instr", instruction, blk[off*32 +: 32]);
    end
    @(posedge clock); #1;
  endtask

  int p0;

  initial begin
    clear_model();
    reset        = 1'b0;
    address      = IDLE;
    mem_busywait = 1'b0;
    mem_readdata = '0;

    // Reset and idle PC
    #2;
    chk("rst_busy", 32'(busywait), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_addr", 32'(mem_address), 32'd0);
    chk("rst_instr", instruction, NOP);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) fetch(IDLE, 0);

    // Cold miss with 3 memory wait cycles, then sequential hits
    mem[28'h0] = 128'h44444444_33333333_22222222_11111111;
    fetch(32'h0, 3);
    chk("cold_word0", instruction, 32'h11111111);
    fetch(32'h4, 0);
    fetch(32'h8, 0);
    fetch(32'hC, 0);
    chk("hit_word3", instruction, 32'h44444444);

    // Other index does not evict index 0; conflicting tag does
    fetch(32'h10, 1);
    fetch(32'h0, 0);
    fetch(32'h80, 2);
    fetch(32'h84, 0);
    fetch(32'h0, 1);
    chk("reload_word0", instruction, 32'h11111111);

    // Reset during MEM_READ
    address      = 32'h40;
    mem_busywait = 1'b1;
    #3;
    chk("pre_rst_busy", 32'(busywait), 32'd1);
    @(posedge clock); #4;
    chk("pre_rst_mem_read", 32'(mem_read), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_mem_read", 32'(mem_read), 32'd0);
    chk("mid_rst_busy", 32'(busywait), 32'd0);
    chk("mid_rst_instr", instruction, NOP);
    @(posedge clock); #1;
    address      = IDLE;
    mem_busywait = 1'b0;
    reset        = 1'b1;
    clear_model();
    fetch(32'h0, 1);
    fetch(32'h40, 0);

    // Back-to-back misses with zero memory wait
    fetch(32'h80, 0);
    p0 = rd_pulses;
    fetch(32'h0, 0);
    fetch(32'h20, 0);
    chk("b2b_pulses", 32'(rd_pulses - p0), 32'd2);

    // Random fetch stream over a small address range to force conflicts
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? IDLE : (32'($urandom_range(0, 127)) << 2);
      fetch(a, $urandom_range(0, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
